// File: rtl/ctu_pkg.sv
// Shared types and constants for the control-transfer unit.
package ctu_pkg;

    // nPC source select encodings
    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_TAG = 2'b01,
        NPC_ALU = 2'b10
    } npc_sel_e;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        SHADOW
    } ctu_state_e;

    // Flush vector bit positions
    localparam int unsigned FL_IFID = 0;
    localparam int unsigned FL_IDEX = 1;

    // Annul fires for an untaken conditional branch or a branch-always, with a set.
    function automatic logic annul_cond(input logic b, input logic ba, input logic bi,
                                        input logic a_bit);
        return (b & ~bi & a_bit) | (ba & a_bit);
    endfunction

endpackage

// File: rtl/ctrl_transfer_unit_if.sv
// Pipeline-side bus of the control-transfer unit.
// Optional macro CTU_PERF_EN adds the CNT_REDIR / CNT_ANNUL counter signals.
interface ctrl_transfer_unit_if #(
    parameter int unsigned NSTAGES = 4,
    parameter int unsigned CW      = 32
);
    logic               STALL;
    logic               B;
    logic               BA;
    logic               BI;
    logic               CALL;
    logic               a_bit;
    logic               J;
    logic               J_L;
    logic [1:0]         nPC_sel;
    logic [NSTAGES-1:0] FLUSH;
    logic               PC_RST;

    if (CW == 0) begin : g_cw_chk
        $error("CW must be at least 1");
    end

`ifdef CTU_PERF_EN
    logic [CW-1:0] CNT_REDIR;
    logic [CW-1:0] CNT_ANNUL;

    modport master (
        output STALL, B, BA, BI, CALL, a_bit, J, J_L,
        input  nPC_sel, FLUSH, PC_RST, CNT_REDIR, CNT_ANNUL
    );
    modport slave (
        input  STALL, B, BA, BI, CALL, a_bit, J, J_L,
        output nPC_sel, FLUSH, PC_RST, CNT_REDIR, CNT_ANNUL
    );
`else
    modport master (
        output STALL, B, BA, BI, CALL, a_bit, J, J_L,
        input  nPC_sel, FLUSH, PC_RST
    );
    modport slave (
        input  STALL, B, BA, BI, CALL, a_bit, J, J_L,
        output nPC_sel, FLUSH, PC_RST
    );
`endif

endinterface

// File: rtl/ctu_boot_seq.sv
// Post-reset boot sequencer: counts boot cycles and drives the PC reset strobe.
module ctu_boot_seq #(
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic clk,
    input  logic R_n,
    input  logic in_boot,
    output logic boot_done,
    output logic pc_rst
);

    localparam int unsigned CntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CntW-1:0] Last = CntW'(RST_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    // Count boot cycles; stops once the last boot cycle is reached
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            cnt_q <= '0;
        end else if (in_boot && !boot_done) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // Done on the final boot cycle so the FSM leaves BOOT on that edge
    always_comb begin
        boot_done = in_boot && (cnt_q == Last);
        pc_rst    = in_boot;
    end

endmodule

// File: rtl/ctrl_transfer_unit.sv
// Control-transfer unit: nPC select, flush vector and PC reset for the in-order pipeline,
// with boot sequencing and delay-slot annulment. Optional macro CTU_PERF_EN adds
// saturating redirect/annul event counters.
module ctrl_transfer_unit
    import ctu_pkg::*;
#(
    parameter int unsigned NSTAGES    = 4,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned CW         = 32
) (
    input  logic                 clk,
    input  logic                 R_n,
    ctrl_transfer_unit_if.slave  bus
);

    if (NSTAGES < 2) begin : g_nst_chk
        $error("NSTAGES must be at least 2");
    end
    if (RST_CYCLES < 1) begin : g_rst_chk
        $error("RST_CYCLES must be at least 1");
    end
    if (CW < 1) begin : g_cw_chk
        $error("CW must be at least 1");
    end

    ctu_state_e         state_q, state_d;
    npc_sel_e           sel;
    logic [NSTAGES-1:0] flush;
    logic               annul_issue;
    logic               boot_done;
    logic               pc_rst;

    ctu_boot_seq #(
        .RST_CYCLES (RST_CYCLES)
    ) u_boot_seq (
        .clk       (clk),
        .R_n       (R_n),
        .in_boot   (state_q == BOOT),
        .boot_done (boot_done),
        .pc_rst    (pc_rst)
    );

    // State register; reset discards any pending annul and restarts boot
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs; EX jumps are older than ID branches and win
    always_comb begin
        state_d     = state_q;
        sel         = NPC_SEQ;
        flush       = '0;
        annul_issue = 1'b0;
        unique case (state_q)
            BOOT: begin
                flush = '1;
                if (boot_done) state_d = RUN;
            end
            RUN: begin
                if (!bus.STALL) begin
                    if (bus.J || bus.J_L) begin
                        sel            = NPC_ALU;
                        flush[FL_IFID] = 1'b1;
                    end else begin
                        if (bus.BI || bus.CALL) sel = NPC_TAG;
                        if (annul_cond(bus.B, bus.BA, bus.BI, bus.a_bit)) state_d = SHADOW;
                    end
                end
            end
            SHADOW: begin
                // Annulled delay slot sits in ID: squash it, ignore its ID events
                if (!bus.STALL) begin
                    flush[FL_IDEX] = 1'b1;
                    annul_issue    = 1'b1;
                    state_d        = RUN;
                    if (bus.J || bus.J_L) begin
                        sel            = NPC_ALU;
                        flush[FL_IFID] = 1'b1;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign bus.nPC_sel = sel;
    assign bus.FLUSH   = flush;
    assign bus.PC_RST  = pc_rst;

`ifdef CTU_PERF_EN
    logic [CW-1:0] cnt_redir_q;
    logic [CW-1:0] cnt_annul_q;

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            cnt_redir_q <= '0;
            cnt_annul_q <= '0;
        end else begin
            if ((sel != NPC_SEQ) && (cnt_redir_q != '1)) cnt_redir_q <= cnt_redir_q + CW'(1);
            if (annul_issue && (cnt_annul_q != '1))      cnt_annul_q <= cnt_annul_q + CW'(1);
        end
    end

    assign bus.CNT_REDIR = cnt_redir_q;
    assign bus.CNT_ANNUL = cnt_annul_q;
`endif

endmodule

// File: tb/tb_ctrl_transfer_unit.sv
// Randomized bench for ctrl_transfer_unit against a behavioural model.
module tb_ctrl_transfer_unit;

    localparam int NST  = 4;
    localparam int RSTC = 2;
    localparam int CW   = 32;

    logic clk = 1'b0;
    logic R_n = 1'b0;
    always #5 clk = ~clk;

    ctrl_transfer_unit_if #(.NSTAGES(NST), .CW(CW)) bus ();

    ctrl_transfer_unit #(
        .NSTAGES    (NST),
        .RST_CYCLES (RSTC),
        .CW         (CW)
    ) dut (
        .clk (clk),
        .R_n (R_n),
        .bus (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Model: boot cycles still to go, whether the ID instruction is an annulled slot
    int            boot_left = RSTC;
    bit            pending   = 1'b0;
    logic [CW-1:0] m_redir   = '0;
    logic [CW-1:0] m_annul   = '0;

    logic [1:0]     e_sel;
    logic [NST-1:0] e_flush;
    logic           e_rst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit jump;
        e_sel   = 2'd0;
        e_flush = '0;
        e_rst   = 1'b0;
        jump    = bus.J || bus.J_L;
        if (!R_n || boot_left > 0) begin
            e_flush = '1;
            e_rst   = 1'b1;
        end else if (!bus.STALL) begin
            if (jump) e_sel = 2'd2;
            else if (!pending && (bus.BI || bus.CALL)) e_sel = 2'd1;
            e_flush[0] = jump;
            e_flush[1] = pending;
        end
    endtask

    task automatic model_advance();
        bit ann;
        if (!R_n) begin
            boot_left = RSTC;
            pending   = 1'b0;
            m_redir   = '0;
            m_annul   = '0;
        end else if (boot_left > 0) begin
            boot_left--;
        end else if (!bus.STALL) begin
            if (e_sel != 2'd0 && m_redir != '1) m_redir++;
            if (pending && m_annul != '1) m_annul++;
            ann = (bus.B && !bus.BI && bus.a_bit) || (bus.BA && bus.a_bit);
            pending = !pending && !(bus.J || bus.J_L) && ann;
        end
    endtask

    // One cycle: drive at negedge, compare 1 time unit later, then advance the model
    task automatic step(input bit rn, input bit stall, input bit b, input bit ba, input bit bi,
                        input bit call, input bit a, input bit j, input bit jl);
        @(negedge clk);
        R_n       = rn;
        bus.STALL = stall;
        bus.B     = b;
        bus.BA    = ba;
        bus.BI    = bi;
        bus.CALL  = call;
        bus.a_bit = a;
        bus.J     = j;
        bus.J_L   = jl;
        #1;
        model_eval();
        chk("nPC_sel", 64'(bus.nPC_sel), 64'(e_sel));
        chk("FLUSH", 64'(bus.FLUSH), 64'(e_flush));
        chk("PC_RST", 64'(bus.PC_RST), 64'(e_rst));
`ifdef CTU_PERF_EN
        chk("CNT_REDIR", 64'(bus.CNT_REDIR), 64'(m_redir));
        chk("CNT_ANNUL", 64'(bus.CNT_ANNUL), 64'(m_annul));
`endif
        model_advance();
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int rst_hold;
        bit ba_r;
        rst_hold = 0;
        // Reset held 3 cycles, then boot for 2 edges
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("lit_rst_flush", 64'(bus.FLUSH), 64'hf);
            chk("lit_rst_pcrst", 64'(bus.PC_RST), 64'h1);
        end
        idle();
        chk("lit_boot0_pcrst", 64'(bus.PC_RST), 64'h1);
        idle();
        chk("lit_boot1_pcrst", 64'(bus.PC_RST), 64'h1);
        chk("lit_boot1_flush", 64'(bus.FLUSH), 64'hf);
        idle();
        chk("lit_run_pcrst", 64'(bus.PC_RST), 64'h0);
        chk("lit_run_flush", 64'(bus.FLUSH), 64'h0);

        // JMPL beats a taken ID branch
        step(1, 0, 0, 0, 1, 0, 0, 0, 1);
        chk("lit_jmpl_sel", 64'(bus.nPC_sel), 64'h2);
        chk("lit_jmpl_flush", 64'(bus.FLUSH), 64'h1);
        idle();
        chk("lit_jmpl_noannul", 64'(bus.FLUSH), 64'h0);
`ifdef CTU_PERF_EN
        chk("lit_cnt_redir", 64'(bus.CNT_REDIR), 64'h1);
`endif

        // Untaken conditional with a set
        step(1, 0, 1, 0, 0, 0, 1, 0, 0);
        chk("lit_bna_sel", 64'(bus.nPC_sel), 64'h0);
        idle();
        chk("lit_bna_flush", 64'(bus.FLUSH), 64'h2);
        idle();
        chk("lit_bna_after", 64'(bus.FLUSH), 64'h0);
`ifdef CTU_PERF_EN
        chk("lit_cnt_annul", 64'(bus.CNT_ANNUL), 64'h1);
`endif

        // BA,a then a 3-cycle stall
        step(1, 0, 0, 1, 1, 0, 1, 0, 0);
        chk("lit_baa_sel", 64'(bus.nPC_sel), 64'h1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0, 0);
            chk("lit_stall_flush", 64'(bus.FLUSH), 64'h0);
        end
        idle();
        chk("lit_unstall_flush", 64'(bus.FLUSH), 64'h2);

        // Annulled slot carrying BI and CALL must not redirect
        step(1, 0, 1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0, 0, 0);
        chk("lit_shadow_sel", 64'(bus.nPC_sel), 64'h0);
        chk("lit_shadow_flush", 64'(bus.FLUSH), 64'h2);

        // Reset while in SHADOW drops the pending annul
        step(1, 0, 1, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_shrst_flush", 64'(bus.FLUSH), 64'hf);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        idle();
        chk("lit_shrst_noannul", 64'(bus.FLUSH), 64'h0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (rst_hold == 0 && $urandom_range(0, 199) == 0) rst_hold = $urandom_range(1, 3);
            ba_r = ($urandom_range(0, 5) == 0);
            step(rst_hold == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 ba_r,
                 ba_r || ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0);
            if (rst_hold > 0) rst_hold--;
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_transfer_unit.md
# ctrl_transfer_unit

Parametrised successor to the single-cycle reset/redirect decoder: produces the nPC source select, a per-stage pipeline flush vector and a PC-reset strobe for the in-order SPARC-style pipeline. It adds a post-reset boot sequencer, architecturally correct delay-slot annulment (a bit) tracked across stalls, and older-instruction-first redirect priority. It sits beside the PC/nPC registers, fed by ID-stage decode and the EX-stage JMPL resolve.

## Interface
- NSTAGES, 4: number of pipeline registers covered by FLUSH (bit0 = IF/ID, bit1 = ID/EX, ...); min 2.
- RST_CYCLES, 2: boot cycles after reset release; min 1.
- CW, 32: width of the performance counters.
- clk  in  1  pipeline clock, rising edge.
- R_n  in  1  reset, asynchronous assert, active low.
- STALL  in  1  pipeline hold; all event inputs are ignored while high.
- B  in  1  conditional branch in ID.
- BA  in  1  branch-always in ID.
- BI  in  1  branch in ID taken (includes BA).
- CALL  in  1  CALL in ID.
- a_bit  in  1  annul bit of the ID instruction (I[29]).
- J, J_L  in  1  jump / JMPL resolved in EX.
- nPC_sel  out  2  00 sequential, 01 TAG, 10 ALU target.
- FLUSH  out  NSTAGES  clear pipeline register k at next edge.
- PC_RST  out  1  force PC=0, nPC=4.
- CNT_REDIR, CNT_ANNUL  out  CW  event counters (only with CTU_PERF_EN).

## Operation
- FSM states: BOOT, RUN, SHADOW. R_n low → BOOT asynchronously, boot counter = 0.
- BOOT: PC_RST=1, FLUSH all ones, nPC_sel=00; counter increments each cycle (STALL ignored); exits to RUN after RST_CYCLES cycles.
- RUN, STALL=0, priority (older first):
  - J or J_L: nPC_sel=10, FLUSH[0]=1; ID events ignored that cycle (DCTI couple unsupported, no annul set).
  - else BI or CALL: nPC_sel=01, FLUSH=0 (delay slot executes).
  - Annul condition: (B & ~BI & a_bit) | (BA & a_bit). When true → SHADOW. Redirect from the same instruction still applies (BA,a: nPC_sel=01 and annul).
- SHADOW: delay slot now in ID. FLUSH[1]=1 on first cycle with STALL=0, then → RUN. While SHADOW, all ID events (B, BA, BI, CALL) are ignored (annulled instruction must not redirect); J/J_L still honoured.
- STALL=1 in RUN/SHADOW: nPC_sel=00, FLUSH=0, state held.
- FLUSH bits ≥2 asserted only in BOOT/reset.

## Timing
- Reset values: nPC_sel=00, FLUSH=all ones, PC_RST=1, counters=0, state=BOOT.
- nPC_sel and FLUSH[0] combinational from inputs (zero latency); FLUSH[1] registered (one cycle after annulling branch, extended by stalls).
- PC_RST deasserts exactly RST_CYCLES rising edges after R_n rises.
- Reset asserted mid-SHADOW or mid-stall: pending annul discarded, BOOT restarts.

## Configuration
- CTU_PERF_EN defined: CNT_REDIR increments each cycle nPC_sel≠00; CNT_ANNUL increments each cycle SHADOW issues FLUSH[1]; both saturate at all ones, cleared only by reset.
- Undefined: counter ports and registers absent; all other behaviour identical.

## Structure
- ctu_pkg: nPC_sel encodings NPC_SEQ/NPC_TAG/NPC_ALU, state enum (BOOT, RUN, SHADOW), flush-index constants FL_IFID, FL_IDEX.
- Sub-module ctu_boot_seq: boot counter and PC_RST generation, parametrised by RST_CYCLES.

## Test plan
- R_n low 3 cycles, release, RST_CYCLES=2 → PC_RST=1 and FLUSH=4'b1111 until 2nd edge after release, then 0/0000.
- B=1, BI=0, a_bit=1 → nPC_sel=00 that cycle; next cycle FLUSH=4'b0010; CNT_ANNUL=1.
- BA=1, BI=1, a_bit=1, then STALL=1 for 3 cycles → nPC_sel=01 at once; FLUSH[1] held 0 during stall, pulses 1 cycle after STALL drops.
- SHADOW with delay-slot BI=1, CALL=1 → nPC_sel=00, no redirect counted.
- J_L=1 with BI=1 same cycle → nPC_sel=10, FLUSH=4'b0001, no annul; CNT_REDIR=1.
- R_n low during SHADOW → FLUSH all ones, annul pulse never issued after boot.
